a2d_rr_sched: RTL



---
 rtl/a2d_rr_sched_if.sv | 21 ++
 rtl/a2d_rr_sched.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/a2d_rr_sched_if.sv
// rtl/a2d_rr_sched_if.sv - SPI monarch handshake bundle between scheduler and monarch
interface a2d_rr_sched_if;
    logic        wrt;
    logic [15:0] wt_data;
    logic        done;
    logic [15:0] rd_data;

    modport master (
        output wrt,
        output wt_data,
        input  done,
        input  rd_data
    );

    modport slave (
        input  wrt,
        input  wt_data,
        output done,
        output rd_data
    );
endinterface

// File: rtl/a2d_rr_sched.sv
// rtl/a2d_rr_sched.sv - round-robin A2D conversion scheduler over four channels
module a2d_rr_sched #(
    parameter logic [2:0] CH_LFT   = 3'd0,
    parameter logic [2:0] CH_RGHT  = 3'd4,
    parameter logic [2:0] CH_STEER = 3'd5,
    parameter logic [2:0] CH_BATT  = 3'd6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  nxt,
    a2d_rr_sched_if.master        spi,
    output logic                  busy,
    output logic                  cnv_cmplt,
    output logic [11:0]           ld_cell_lft,
    output logic [11:0]           ld_cell_rght,
    output logic [11:0]           steerPot,
    output logic [11:0]           batt
);

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        WAIT1,
        DEAD,
        READ,
        WAIT2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  rr_ptr;
    logic [2:0]  cur_ch;
    logic        wrt_q;
    logic        wrt_nxt;
    logic [15:0] wt_data_q;
    logic [15:0] wt_data_nxt;
    logic        busy_nxt;
    logic        cmplt_nxt;
    logic        capture;

    assign spi.wrt     = wrt_q;
    assign spi.wt_data = wt_data_q;

    // Map the rotation pointer onto the physical A2D channel number
    always_comb begin
        cur_ch = CH_LFT;
        case (rr_ptr)
            2'd0:    cur_ch = CH_LFT;
            2'd1:    cur_ch = CH_RGHT;
            2'd2:    cur_ch = CH_STEER;
            default: cur_ch = CH_BATT;
        endcase
    end

    // Next-state and next-output decode; outputs are registered so each
    // transition below describes what the following cycle will show
    always_comb begin
        state_nxt   = state;
        wrt_nxt     = 1'b0;
        wt_data_nxt = wt_data_q;
        busy_nxt    = busy;
        cmplt_nxt   = 1'b0;
        capture     = 1'b0;
        case (state)
            IDLE: begin
                if (nxt) begin
                    state_nxt   = CMD;
                    wrt_nxt     = 1'b1;
                    wt_data_nxt = {2'b00, cur_ch, 11'h000};
                    busy_nxt    = 1'b1;
                end
            end
            CMD: begin
                state_nxt = WAIT1;
            end
            WAIT1: begin
                // First response carries nothing useful; only its arrival matters
                if (spi.done) begin
                    state_nxt = DEAD;
                end
            end
            DEAD: begin
                // One dead cycle lets SS_n recover before the read transaction
                state_nxt   = READ;
                wrt_nxt     = 1'b1;
                wt_data_nxt = 16'h0000;
            end
            READ: begin
                state_nxt = WAIT2;
            end
            WAIT2: begin
                if (spi.done) begin
                    state_nxt = IDLE;
                    capture   = 1'b1;
                    cmplt_nxt = 1'b1;
                    busy_nxt  = 1'b0;
                end
            end
            default: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    // State and registered handshake outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            wrt_q     <= 1'b0;
            wt_data_q <= 16'h0000;
            busy      <= 1'b0;
            cnv_cmplt <= 1'b0;
        end else begin
            state     <= state_nxt;
            wrt_q     <= wrt_nxt;
            wt_data_q <= wt_data_nxt;
            busy      <= busy_nxt;
            cnv_cmplt <= cmplt_nxt;
        end
    end

    // Rotation pointer advances only when a result has been captured
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= 2'd0;
        end else if (capture) begin
            rr_ptr <= rr_ptr + 2'd1;
        end
    end

    // Result holding registers; upper four bits of the read word are dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ld_cell_lft  <= 12'h000;
            ld_cell_rght <= 12'h000;
            steerPot     <= 12'h000;
            batt         <= 12'h000;
        end else if (capture) begin
            case (rr_ptr)
                2'd0:    ld_cell_lft  <= spi.rd_data[11:0];
                2'd1:    ld_cell_rght <= spi.rd_data[11:0];
                2'd2:    steerPot     <= spi.rd_data[11:0];
                default: batt         <= spi.rd_data[11:0];
            endcase
        end
    end

endmodule
